// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage load/store engine: access codes, FSM states,
// access sizes and byte-enable patterns.
package mem_access_pkg;

    typedef enum logic [2:0] {
        LD_W    = 3'b000,
        LD_H    = 3'b001,
        LD_HU   = 3'b010,
        LD_B    = 3'b011,
        LD_BU   = 3'b100,
        LD_NONE = 3'b101
    } mem_read_e;

    typedef enum logic [1:0] {
        ST_W    = 2'b00,
        ST_H    = 2'b01,
        ST_B    = 2'b10,
        ST_NONE = 2'b11
    } mem_write_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = BE_BYTE0 << lane;
            SZ_HALF: be = lane[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory bus with a req/ack handshake; the access unit is the master.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-3:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extender.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_extender
    import mem_access_pkg::*;
(
    input  mem_read_e   ld_type,
    input  logic [1:0]  lane,
    input  logic [31:0] raw,
    output logic [31:0] value
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw[{lane, 3'b000} +: 8];
        half_v = lane[1] ? raw[31:16] : raw[15:0];
        case (ld_type)
            LD_B:    value = {{24{byte_v[7]}}, byte_v};
            LD_BU:   value = {24'h0, byte_v};
            LD_H:    value = {{16{half_v[15]}}, half_v};
            LD_HU:   value = {16'h0, half_v};
            default: value = raw;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: decodes load/store codes, rejects misaligned
// accesses, runs one bus transaction per access. Optional bus-ack timeout: MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an access; aligned access is accepted this cycle
// BUSY  | bus_req held with registered fields until bus_ack (or timeout)
// DONE  | pipeline released; load_valid / bus_err pulse; inputs ignored
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mem_read,
    input  logic [1:0]        mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              bus_err,
    mem_access_unit_if.master bus
);
    state_e      state;
    mem_read_e   ld_type_q;
    logic [1:0]  lane_q;
    logic [31:0] ext_data;

    logic        is_store;
    logic        is_load;
    logic        present;
    logic        bad_align;
    logic        accept;
    size_e       size;
    mem_read_e   ld_kind;
    logic [31:0] wdata;

    // A store wins over a load when both codes are present.
    always_comb begin
        is_store = (mem_write != ST_NONE);
        is_load  = (mem_read <= LD_BU);
        ld_kind  = LD_NONE;
        size     = SZ_WORD;
        wdata    = store_data;
        if (is_store) begin
            case (mem_write)
                ST_H:    begin size = SZ_HALF; wdata = {2{store_data[15:0]}}; end
                ST_B:    begin size = SZ_BYTE; wdata = {4{store_data[7:0]}};  end
                default: ;
            endcase
        end else if (is_load) begin
            ld_kind = mem_read_e'(mem_read);
            case (ld_kind)
                LD_H, LD_HU: size = SZ_HALF;
                LD_B, LD_BU: size = SZ_BYTE;
                default:     ;
            endcase
        end
    end

    assign present   = is_store || is_load;
    assign bad_align = is_misaligned(size, addr[1:0]);
    assign accept    = (state == IDLE) && present && !bad_align;
    assign misalign  = !reset && (state == IDLE) && present && bad_align;
    assign stall     = !reset && (accept || (state == BUSY));

    load_extender u_load_extender (
        .ld_type (ld_type_q),
        .lane    (lane_q),
        .raw     (bus.bus_rdata),
        .value   (ext_data)
    );

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign bus_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ld_type_q     <= LD_NONE;
            lane_q        <= 2'b00;
            load_data     <= '0;
            load_valid    <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
            bus_err       <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            load_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= BUSY;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= is_store;
                        bus.bus_addr  <= addr[ADDR_W-1:2];
                        bus.bus_be    <= byte_enables(size, addr[1:0]);
                        bus.bus_wdata <= is_store ? wdata : 32'h0;
                        ld_type_q     <= is_store ? LD_NONE : ld_kind;
                        lane_q        <= addr[1:0];
`ifdef MEM_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        state       <= DONE;
                        bus.bus_req <= 1'b0;
                        if (ld_type_q != LD_NONE) begin
                            load_data  <= ext_data;
                            load_valid <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    // Count reaches TIMEOUT at this edge: abort instead of waiting on.
                    else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state       <= DONE;
                        bus.bus_req <= 1'b0;
                        bus_err     <= 1'b1;
                        if (ld_type_q != LD_NONE) begin
                            load_data <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan cases plus randomized
// accesses against an arithmetic reference model of the load/store rules.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(255)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Observations collected by do_access
    int          o_stall, o_mis, o_req, o_lv, o_cycles;
    bit          o_done, o_stable;
    logic        o_we;
    logic [29:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata, o_ld;
    logic [31:0] last_ld;

    // Reference model: plain arithmetic on the access rules
    function automatic int ref_size(input logic [2:0] rd, input logic [1:0] wr);
        if (wr != 2'd3) return (wr == 2'd0) ? 4 : (wr == 2'd1) ? 2 : 1;
        if (rd <= 3'd4) return (rd == 3'd0) ? 4 : (rd <= 3'd2) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit ref_misaligned(input int sz, input logic [31:0] a);
        return (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] ref_be(input int sz, input logic [31:0] a);
        if (sz == 1) return 4'(1 << (a % 4));
        if (sz == 2) return (a % 4 >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] sd);
        if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] rd, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        case (rd)
            3'd1, 3'd2: begin
                v = (w >> ((a & 32'd2) * 32'd8)) & 32'hFFFF;
                if (rd == 3'd1 && v >= 32'h8000) v = v - 32'h1_0000;
            end
            3'd3, 3'd4: begin
                v = (w >> ((a & 32'd3) * 32'd8)) & 32'hFF;
                if (rd == 3'd3 && v >= 32'h80) v = v - 32'h100;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // Drives one access, plays the memory (ack after 'delay' idle BUSY cycles), records what it saw
    task automatic do_access(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rdata, input int delay);
        int j;
        j = 0;
        o_stall = 0; o_mis = 0; o_req = 0; o_lv = 0; o_cycles = 0;
        o_done = 0; o_stable = 1;
        o_we = 0; o_addr = '0; o_be = '0; o_wdata = '0; o_ld = '0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; store_data = sd;
        for (int c = 0; c < 60 && !o_done; c++) begin
            @(negedge clk);
            o_cycles++;
            if (stall) o_stall++;
            if (misalign) o_mis++;
            if (load_valid) begin o_lv++; o_ld = load_data; end
            if (bus.bus_req) begin
                j++;
                o_req++;
                if (j == 1) begin
                    o_we = bus.bus_we; o_addr = bus.bus_addr; o_be = bus.bus_be; o_wdata = bus.bus_wdata;
                end else if (o_we !== bus.bus_we || o_addr !== bus.bus_addr ||
                             o_be !== bus.bus_be || o_wdata !== bus.bus_wdata) begin
                    o_stable = 0;
                end
                bus.bus_ack   = (j == delay + 1);
                bus.bus_rdata = rdata;
            end else begin
                bus.bus_ack = 1'b0;
                if (!stall) begin
                    o_done = 1;
                    mem_read = 3'b101; mem_write = 2'b11;
                end
            end
        end
        @(negedge clk);
        if (stall) o_stall++;
        if (misalign) o_mis++;
        if (load_valid) o_lv++;
        n_vec++;
        if (!o_done) begin
            n_err++;
            $display("FAIL access_done: access rd=%0d wr=%0d never completed", rd, wr);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mem_read = 3'b101; mem_write = 2'b11; addr = '0; store_data = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({stall, load_valid, misalign, bus_err, bus.bus_req, bus.bus_we} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                     {stall, load_valid, misalign, bus_err, bus.bus_req, bus.bus_we});
        end
        n_vec++;
        if ({load_data, bus.bus_addr, bus.bus_be, bus.bus_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: load_data=%h addr=%h be=%b wdata=%h want zeros",
                     load_data, bus.bus_addr, bus.bus_be, bus.bus_wdata);
        end
        mem_read = 3'b000; #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall: got %b want 0 while in reset", stall);
        end
        mem_read = 3'b101;
        @(negedge clk);
        reset = 1'b0;
        last_ld = '0;
    endtask

    task automatic test_lb;
        do_access(3'b011, 2'b11, 32'h103, 32'h0, 32'h80FF_1234, 0);
        n_vec++;
        if (o_be !== 4'b1000) begin n_err++; $display("FAIL lb_be: got %b want 1000", o_be); end
        n_vec++;
        if (o_ld !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h want ffffff80", o_ld); end
        n_vec++;
        if (o_lv !== 1 || o_cycles !== 3) begin
            n_err++; $display("FAIL lb_valid: load_valid count %0d at cycle %0d, want 1 at cycle 3", o_lv, o_cycles);
        end
        n_vec++;
        if (o_stall !== 2) begin n_err++; $display("FAIL lb_stall: got %0d cycles want 2", o_stall); end
        last_ld = 32'hFFFF_FF80;
    endtask

    task automatic test_sh;
        do_access(3'b101, 2'b01, 32'h202, 32'hDEAD_BEEF, 32'h0, 1);
        n_vec++;
        if ({o_we, o_addr, o_be} !== {1'b1, 30'h80, 4'b1100}) begin
            n_err++; $display("FAIL sh_fields: we=%b addr=%h be=%b want 1/80/1100", o_we, o_addr, o_be);
        end
        n_vec++;
        if (o_wdata !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_wdata: got %h want beefbeef", o_wdata); end
        n_vec++;
        if (o_lv !== 0 || load_data !== last_ld) begin
            n_err++; $display("FAIL sh_noload: load_valid %0d load_data %h want 0/%h", o_lv, load_data, last_ld);
        end
    endtask

    task automatic test_misalign;
        do_access(3'b000, 2'b11, 32'h6, 32'h0, 32'h1234_5678, 0);
        n_vec++;
        if (o_mis !== 1) begin n_err++; $display("FAIL mis_pulse: got %0d pulses want 1", o_mis); end
        n_vec++;
        if (o_req !== 0 || o_stall !== 0) begin
            n_err++; $display("FAIL mis_nobus: req %0d stall %0d want 0/0", o_req, o_stall);
        end
        n_vec++;
        if (load_data !== last_ld) begin n_err++; $display("FAIL mis_keep: load_data %h want %h", load_data, last_ld); end
    endtask

    task automatic test_lhu_delay;
        do_access(3'b010, 2'b11, 32'h2, 32'h0, 32'h9ABC_0000, 4);
        n_vec++;
        if (!o_stable || o_req !== 5) begin
            n_err++; $display("FAIL lhu_stable: stable %0d req cycles %0d want 1/5", o_stable, o_req);
        end
        n_vec++;
        if (o_ld !== 32'h0000_9ABC) begin n_err++; $display("FAIL lhu_data: got %h want 00009abc", o_ld); end
        n_vec++;
        if (o_stall !== 6) begin n_err++; $display("FAIL lhu_stall: got %0d want 6", o_stall); end
        last_ld = 32'h0000_9ABC;
    endtask

    task automatic test_stray_ack;
        @(posedge clk); #1;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (bus.bus_req !== 1'b0 || stall !== 1'b0 || load_valid !== 1'b0 || load_data !== last_ld) begin
                n_err++;
                $display("FAIL stray_ack: req %b stall %b lv %b data %h want 0/0/0/%h",
                         bus.bus_req, stall, load_valid, load_data, last_ld);
            end
        end
        bus.bus_ack = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        mem_read = 3'b000; mem_write = 2'b11; addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.bus_req !== 1'b1) begin n_err++; $display("FAIL rst_busy: bus_req %b want 1", bus.bus_req); end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (bus.bus_req !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL rst_async: req %b stall %b want 0/0", bus.bus_req, stall);
        end
        @(negedge clk);
        mem_read = 3'b101;
        reset = 1'b0;
        last_ld = '0;
        do_access(3'b001, 2'b11, 32'h22, 32'h0, 32'h8001_7FFF, 1);
        n_vec++;
        if (o_ld !== 32'hFFFF_8001 || o_lv !== 1 || o_stall !== 3) begin
            n_err++; $display("FAIL rst_after: data %h lv %0d stall %0d want ffff8001/1/3", o_ld, o_lv, o_stall);
        end
        last_ld = 32'hFFFF_8001;
    endtask

    task automatic test_random;
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [31:0] a, sd, w, exp_ld;
        int          sz, dly;
        bit          bad;
        for (int k = 0; k < 60; k++) begin
            rd  = 3'($urandom_range(0, 7));
            wr  = 2'($urandom_range(0, 3));
            a   = $urandom;
            sd  = $urandom;
            w   = $urandom;
            dly = $urandom_range(0, 3);
            sz  = ref_size(rd, wr);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2) a[0] = 1'b0;
                if (sz == 4) a[1:0] = 2'b00;
            end
            bad = ref_misaligned(sz, a);
            do_access(rd, wr, a, sd, w, dly);
            if (sz == 0 || bad) begin
                n_vec++;
                if (o_req !== 0 || o_stall !== 0 || o_lv !== 0 || o_mis !== (sz == 0 ? 0 : 1)) begin
                    n_err++;
                    $display("FAIL rnd_reject: rd=%0d wr=%0d a=%h req %0d stall %0d lv %0d mis %0d",
                             rd, wr, a, o_req, o_stall, o_lv, o_mis);
                end
            end else begin
                n_vec++;
                if (o_req !== dly + 1 || o_stall !== dly + 2 || o_mis !== 0 || !o_stable) begin
                    n_err++;
                    $display("FAIL rnd_timing: rd=%0d wr=%0d req %0d stall %0d mis %0d stable %0d want %0d/%0d/0/1",
                             rd, wr, o_req, o_stall, o_mis, o_stable, dly + 1, dly + 2);
                end
                n_vec++;
                if (o_we !== (wr != 2'd3) || o_addr !== a[31:2] || o_be !== ref_be(sz, a)) begin
                    n_err++;
                    $display("FAIL rnd_fields: we %b addr %h be %b want %b/%h/%b",
                             o_we, o_addr, o_be, (wr != 2'd3), a[31:2], ref_be(sz, a));
                end
                if (wr != 2'd3) begin
                    n_vec++;
                    if (o_wdata !== ref_wdata(sz, sd) || o_lv !== 0 || load_data !== last_ld) begin
                        n_err++;
                        $display("FAIL rnd_store: wdata %h lv %0d data %h want %h/0/%h",
                                 o_wdata, o_lv, load_data, ref_wdata(sz, sd), last_ld);
                    end
                end else begin
                    exp_ld = ref_load(rd, a, w);
                    n_vec++;
                    if (o_ld !== exp_ld || o_lv !== 1) begin
                        n_err++;
                        $display("FAIL rnd_load: rd=%0d a=%h word %h got %h lv %0d want %h/1",
                                 rd, a, w, o_ld, o_lv, exp_ld);
                    end
                    last_ld = exp_ld;
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_sh;
        test_misalign;
        test_lhu_delay;
        test_stray_ack;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine; the consumer of the Controller's MemRead/MemWrite codes.
- Decodes those codes, checks alignment, and drives a word-wide data-memory bus with a req/ack handshake.
- Stalls the pipeline while a transaction is outstanding, then returns lane-aligned, sign- or zero-extended load data.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, bus-ack wait limit in cycles; used only with MEM_TIMEOUT_EN; must be below 2^8.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- mem_read  in  3  load code: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 none; 110/111 treated as none.
- mem_write  in  2  store code: 00 SW, 01 SH, 10 SB, 11 none.
- addr  in  ADDR_W  byte address (ALU result).
- store_data  in  32  rs2 value.
- stall  out  1  freeze upstream pipeline.
- load_data  out  32  extended load result.
- load_valid  out  1  one-cycle pulse; load_data valid.
- misalign  out  1  one-cycle pulse; access rejected.
- bus_err  out  1  one-cycle pulse; timeout abort.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W-2  word address.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-positioned write data.
- bus_ack  in  1  completion; valid only while bus_req=1.
- bus_rdata  in  32  read word; valid with bus_ack on reads.

Behaviour:
- Reset: state IDLE. stall, load_valid, misalign, bus_err, bus_req, bus_we = 0. load_data, bus_addr, bus_be, bus_wdata = 0. Reset asserted mid-transaction drops bus_req immediately and abandons the access.
- Access present: mem_read is a valid load code, or mem_write != 11. If both a load and a store are present, the store wins.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE, misalign pulses that cycle (combinational).
  - No bus transaction, stall stays 0, load_data is unchanged.
- FSM states: IDLE, BUSY, DONE.
- IDLE, aligned access present:
  - stall=1 combinationally in the same cycle.
  - At the edge: latch the bus fields and load type, go to BUSY.
- BUSY:
  - bus_req=1 and stall=1.
  - bus_addr, bus_we, bus_be, bus_wdata are registered and held stable until ack.
  - On bus_ack: capture the extended bus_rdata into load_data (loads only), go to DONE.
- DONE:
  - stall=0; load_valid=1 for loads only; go to IDLE.
  - Inputs are ignored in DONE, since they still carry the same instruction.
- Minimum access latency: 3 cycles (accept, BUSY with ack, DONE). Each extra cycle without bus_ack adds one cycle.
- bus_ack outside BUSY is ignored.
- Byte enables:
  - SB/LB/LBU: be = 1 << addr[1:0].
  - SH/LH/LHU: be = addr[1] ? 1100 : 0011.
  - SW/LW: 1111.
- Write data: SB replicates byte [7:0] to all four lanes; SH replicates [15:0] to both halves; SW passes through.
- Load extension:
  - LB/LBU take lane addr[1:0]; LH/LHU take half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Loads issue bus_be as above; memory may ignore bus_be on reads.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT, go to DONE with bus_err=1 for one cycle.
  - On a timed-out load, load_data=0 and load_valid=0.
  - If ack coincides with count==TIMEOUT, ack wins.
- Undefined: BUSY waits indefinitely; bus_err is tied to 0; no counter exists.

Decomposition:
- Package mem_access_pkg:
  - enums for the mem_read codes (incl. none=101) and mem_write codes (none=11);
  - state enum (IDLE/BUSY/DONE);
  - constants for the byte-enable patterns.
- One combinational sub-module, load_extender: inputs load type, addr[1:0], raw word; output extended 32-bit value.

Test Plan:
- LB at addr 0x103, bus_rdata=0x80FF_1234, ack on first BUSY cycle -> bus_be=1000, load_data=0xFFFF_FF80, load_valid in cycle 3, stall high cycles 1-2 only.
- SH at addr 0x202, store_data=0xDEAD_BEEF -> bus_we=1, bus_addr=0x80, bus_be=1100, bus_wdata=0xBEEF_BEEF; no load_valid.
- LW at addr 0x6 -> misalign pulse, bus_req never asserts, stall=0.
- LHU at addr 0x2, ack delayed 5 cycles, bus_rdata=0x9ABC_0000 -> bus fields stable throughout, load_data=0x0000_9ABC, stall high 6 cycles.
- Reset asserted during BUSY -> bus_req and stall drop asynchronously; next access proceeds normally.
- With MEM_TIMEOUT_EN and TIMEOUT=4, no ack -> bus_err pulse after 4 BUSY cycles, load_valid=0, FSM back to IDLE.
